fetch_sequencer: RTL and testbench

- Sequences reads from the combinational instruction ROM (1024 bytes, byte addressed, word aligned; reads at or past the end return X).
- Holds the fetch PC and buffers fetched {pc, instruction} pairs in a small FIFO that decode drains with a valid/ready handshake.
- Handles redirects from branch resolution, end-of-memory halt, and misaligned-target faults, so the ROM never sees an out-of-range or unaligned address that gets used.

---
 rtl/fetch_sequencer.sv | 91 +++++++++
 tb/tb_fetch_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the ROM address from the fetch pc, buffers
// {pc, instr} pairs in a small circular queue, and handles redirect/halt/fault.
module fetch_sequencer #(
  parameter int          MEM_SIZE = 1024,
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [63:0]              imem_addr,
  input  logic [31:0]              imem_instr,
  input  logic                     redirect_valid,
  input  logic [63:0]              redirect_pc,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [31:0]              deq_instr,
  output logic [63:0]              deq_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     fetch_halted,
  output logic                     align_fault
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef enum logic [1:0] {S_FETCH, S_HALT, S_FAULT} state_t;

  entry_t          q [DEPTH];
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   cnt;
  logic [63:0]     pc;
  state_t          state;
  logic            in_range, deq_fire, enq_ok;

  // the ROM word is only captured while the whole word lies inside the ROM
  assign in_range  = (pc + 64'd3) < 64'(MEM_SIZE);
  assign deq_valid = (cnt != '0);
  assign deq_fire  = deq_valid && deq_ready;
  assign enq_ok    = (state == S_FETCH) && ((cnt < CW'(DEPTH)) || deq_fire) && in_range;

  assign imem_addr = pc;
  assign count     = cnt;
  assign deq_instr = deq_valid ? q[head].instr : '0;
  assign deq_pc    = deq_valid ? q[head].pc    : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc           <= RESET_PC;
      head         <= '0;
      tail         <= '0;
      cnt          <= '0;
      state        <= S_FETCH;
      fetch_halted <= 1'b0;
      align_fault  <= 1'b0;
    end else if (redirect_valid) begin
      // flush discards any same-cycle enqueue or dequeue
      head         <= '0;
      tail         <= '0;
      cnt          <= '0;
      pc           <= redirect_pc;
      fetch_halted <= 1'b0;
      if (redirect_pc[1:0] == 2'b00) begin
        state       <= S_FETCH;
        align_fault <= 1'b0;
      end else begin
        state       <= S_FAULT;
        align_fault <= 1'b1;
      end
    end else begin
      if (deq_fire) head <= head + AW'(1);
      if (enq_ok) begin
        q[tail] <= '{pc: pc, instr: imem_instr};
        tail    <= tail + AW'(1);
        pc      <= pc + 64'd4;
      end
      case ({enq_ok, deq_fire})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (state == S_FETCH && !enq_ok && !in_range) begin
        state        <= S_HALT;
        fetch_halted <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: ROM model plus a scoreboard of expected
// {pc, instr} pairs that is popped whenever decode accepts the queue head.
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        deq_valid, deq_ready;
  logic [31:0] deq_instr;
  logic [63:0] deq_pc;
  logic [2:0]  count;
  logic        fetch_halted, align_fault;

  int checks   = 0;
  int failures = 0;
  logic [95:0] sb [$];

  always #5 clk = ~clk;

  function automatic logic [31:0] romw(input logic [63:0] addr);
    logic [31:0] idx;
    idx = {22'd0, addr[9:2]};
    return (idx * 32'h0101_0013) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_instr = (imem_addr < 64'd1024) ? romw(imem_addr) : 32'hxxxx_xxxx;

  fetch_sequencer #(.MEM_SIZE(1024), .DEPTH(4), .RESET_PC(64'd0)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_instr(deq_instr),
    .deq_pc(deq_pc), .count(count), .fetch_halted(fetch_halted),
    .align_fault(align_fault)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_seq(input logic [63:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [63:0] a;
      a = start + 64'(4 * i);
      if (a + 64'd3 < 64'd1024) sb.push_back({a, romw(a)});
    end
  endtask

  // called at a negedge with inputs settled; checks any accepted head, then
  // advances to the next negedge
  task automatic cycle();
    logic [95:0] e;
    chk("no_x_instr", 64'($isunknown(deq_instr)), 64'd0);
    if (reset && !redirect_valid && deq_valid && deq_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow_pc", deq_pc, 64'hDEAD_DEAD_DEAD_DEAD);
      end else begin
        e = sb.pop_front();
        chk("deq_pc", deq_pc, e[95:32]);
        chk("deq_instr", {32'd0, deq_instr}, {32'd0, e[31:0]});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic redirect(input logic [63:0] tgt, input int n);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    sb.delete();
    if (tgt[1:0] == 2'b00) push_seq(tgt, n);
    cycle();
    redirect_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; deq_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    @(negedge clk);
    cycle(); cycle();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(deq_valid), 64'd0);
    chk("rst_instr", {32'd0, deq_instr}, 64'd0);
    chk("rst_pc", deq_pc, 64'd0);
    chk("rst_halt", 64'(fetch_halted), 64'd0);
    chk("rst_fault", 64'(align_fault), 64'd0);
    chk("rst_addr", imem_addr, 64'd0);

    // fill to full with no consumer
    reset = 1'b1;
    push_seq(64'd0, 12);
    repeat (4) cycle();
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_head_pc", deq_pc, 64'd0);
    chk("fill_head_instr", {32'd0, deq_instr}, {32'd0, romw(64'd0)});
    chk("fill_addr", imem_addr, 64'd16);
    cycle();
    chk("stall_addr", imem_addr, 64'd16);
    chk("stall_count", 64'(count), 64'd4);

    // full with concurrent dequeue keeps count constant
    deq_ready = 1'b1;
    repeat (3) cycle();
    deq_ready = 1'b0;
    chk("fulldq_count", 64'(count), 64'd4);
    chk("fulldq_head", deq_pc, 64'd12);
    chk("fulldq_addr", imem_addr, 64'd28);

    // redirect to 0x40 while full
    redirect(64'h40, 8);
    chk("rd_count", 64'(count), 64'd0);
    chk("rd_valid", 64'(deq_valid), 64'd0);
    chk("rd_addr", imem_addr, 64'h40);
    cycle();
    chk("rd_valid2", 64'(deq_valid), 64'd1);
    chk("rd_pc2", deq_pc, 64'h40);
    chk("rd_instr2", {32'd0, deq_instr}, {32'd0, romw(64'h40)});
    chk("rd_count2", 64'(count), 64'd1);
    deq_ready = 1'b1;
    repeat (4) cycle();
    chk("tput_valid", 64'(deq_valid), 64'd1);

    // end of memory: 1016, 1020 then halt and drain
    redirect(64'd1016, 4);
    repeat (3) cycle();
    chk("eom_halt", 64'(fetch_halted), 64'd1);
    chk("eom_count", 64'(count), 64'd0);
    chk("eom_addr", imem_addr, 64'd1024);
    chk("eom_sb_empty", 64'(sb.size()), 64'd0);
    repeat (3) cycle();
    chk("eom_instr0", {32'd0, deq_instr}, 64'd0);
    chk("eom_halt2", 64'(fetch_halted), 64'd1);

    // misaligned target faults until an aligned redirect
    deq_ready = 1'b0;
    redirect(64'h42, 0);
    chk("flt_fault", 64'(align_fault), 64'd1);
    chk("flt_count", 64'(count), 64'd0);
    repeat (4) cycle();
    chk("flt_valid", 64'(deq_valid), 64'd0);
    chk("flt_hold_addr", imem_addr, 64'h42);
    redirect(64'h44, 4);
    chk("flt_clear", 64'(align_fault), 64'd0);
    cycle();
    chk("flt_rec_valid", 64'(deq_valid), 64'd1);
    chk("flt_rec_pc", deq_pc, 64'h44);

    // halt holding three entries, then reset
    redirect(64'd1012, 4);
    repeat (4) cycle();
    chk("hq_halt", 64'(fetch_halted), 64'd1);
    chk("hq_count", 64'(count), 64'd3);
    reset = 1'b0;
    cycle();
    chk("hr_count", 64'(count), 64'd0);
    chk("hr_halt", 64'(fetch_halted), 64'd0);
    chk("hr_addr", imem_addr, 64'd0);

    // reset wins over a simultaneous redirect
    redirect_valid = 1'b1; redirect_pc = 64'h82;
    cycle();
    redirect_valid = 1'b0;
    chk("rw_addr", imem_addr, 64'd0);
    chk("rw_fault", 64'(align_fault), 64'd0);
    chk("rw_count", 64'(count), 64'd0);

    // empty with deq_ready high: no underflow, then restart from reset pc
    reset = 1'b1; deq_ready = 1'b1;
    sb.delete();
    push_seq(64'd0, 12);
    cycle();
    chk("rs_count", 64'(count), 64'd1);
    repeat (5) cycle();
    chk("rs_tput_count", 64'(count), 64'd1);
    chk("rs_head", deq_pc, 64'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
